// File: rtl/io_periph_pkg.sv
// Shared address map and region decode for the IO peripheral bank.
package io_periph_pkg;

  localparam logic [15:0] LEDR_BASE = 16'h7000;
  localparam logic [15:0] LEDG_BASE = 16'h7010;
  localparam logic [15:0] HEX_BASE  = 16'h7020;
  localparam logic [15:0] LCD_BASE  = 16'h7030;
  localparam logic [15:0] SW_BASE   = 16'h7800;

  typedef enum logic [2:0] {
    RGN_NONE,
    RGN_LEDR,
    RGN_LEDG,
    RGN_HEX,
    RGN_LCD,
    RGN_SW
  } region_e;

  // Word address is addr[15:2]; the HEX block spans four words (16 digit bytes).
  function automatic region_e decode_region(input logic [13:0] word);
    region_e r;
    r = RGN_NONE;
    if (word == LEDR_BASE[15:2])             r = RGN_LEDR;
    else if (word == LEDG_BASE[15:2])        r = RGN_LEDG;
    else if (word[13:2] == HEX_BASE[15:4])   r = RGN_HEX;
    else if (word == LCD_BASE[15:2])         r = RGN_LCD;
    else if (word == SW_BASE[15:2])          r = RGN_SW;
    return r;
  endfunction

endpackage

// File: rtl/io_periph_bank_sw_debounce.sv
// Single-bit switch filter: the output follows the synchronised input only
// after it has disagreed for CYC consecutive cycles.
module sw_debounce #(
  parameter int unsigned CYC = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sync_i,
  output logic filt_o
);

  logic        filt_q, filt_d;
  logic [15:0] cnt_q, cnt_d;

  // Count disagreeing cycles; any agreement restarts the count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_i != filt_q) begin
      if (cnt_q == 16'(CYC - 1)) filt_d = sync_i;
      else                       cnt_d  = cnt_q + 16'd1;
    end
  end

  // Filter state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/io_periph_bank.sv
// Memory-mapped LED / 7-segment / LCD outputs and switch input for the LSU.
// Optional switch debounce is enabled by defining IO_DEBOUNCE_EN.
module io_periph_bank
  import io_periph_pkg::*;
#(
  parameter int unsigned NUM_HEX      = 8,
  parameter int unsigned LEDR_W       = 17,
  parameter int unsigned LEDG_W       = 8,
  parameter int unsigned SW_W         = 17,
  parameter int unsigned DEBOUNCE_CYC = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  input  logic [3:0]           bmask_i,
  input  logic                 wren_i,
  input  logic                 rden_i,
  output logic [31:0]          rdata_o,
  output logic                 rvalid_o,
  input  logic [SW_W-1:0]      io_sw_i,
  output logic [LEDR_W-1:0]    io_ledr_o,
  output logic [LEDG_W-1:0]    io_ledg_o,
  output logic [31:0]          io_lcd_o,
  output logic [7*NUM_HEX-1:0] io_hex_o
);

  region_e                    rgn;
  logic [LEDR_W-1:0]          ledr_q, ledr_d;
  logic [LEDG_W-1:0]          ledg_q, ledg_d;
  logic [31:0]                lcd_q, lcd_d;
  logic [NUM_HEX-1:0][6:0]    hex_q, hex_d;
  logic [SW_W-1:0]            sw_sync1_q, sw_sync2_q, sw_filt;
  logic [31:0]                rdata_q, rdata_d;
  logic                       rvalid_q;
  logic                       unused_addr;

  assign rgn         = decode_region(addr_i[15:2]);
  assign unused_addr = ^{addr_i[31:16], addr_i[1:0]};

  // Store path: byte-enabled merge into whichever register the address hits.
  always_comb begin
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    lcd_d  = lcd_q;
    hex_d  = hex_q;
    if (wren_i) begin
      case (rgn)
        RGN_LEDR: for (int k = 0; k < LEDR_W; k++) if (bmask_i[k/8]) ledr_d[k] = wdata_i[k];
        RGN_LEDG: for (int k = 0; k < LEDG_W; k++) if (bmask_i[k/8]) ledg_d[k] = wdata_i[k];
        RGN_LCD:  for (int k = 0; k < 32; k++)     if (bmask_i[k/8]) lcd_d[k]  = wdata_i[k];
        RGN_HEX:
          for (int i = 0; i < NUM_HEX; i++)
            if (addr_i[3:2] == 2'(i/4) && bmask_i[i%4]) hex_d[i] = wdata_i[8*(i%4) +: 7];
        default: ;
      endcase
    end
  end

  // Load path: reads the pre-edge register contents, so a same-cycle store is not visible.
  always_comb begin
    rdata_d = '0;
    case (rgn)
      RGN_LEDR: rdata_d = 32'(ledr_q);
      RGN_LEDG: rdata_d = 32'(ledg_q);
      RGN_LCD:  rdata_d = lcd_q;
      RGN_SW:   rdata_d = 32'(sw_filt);
      RGN_HEX:
        for (int i = 0; i < NUM_HEX; i++)
          if (addr_i[3:2] == 2'(i/4)) rdata_d[8*(i%4) +: 8] = {1'b0, hex_q[i]};
      default: ;
    endcase
  end

  // Output registers, switch synchroniser and registered load response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ledr_q     <= '0;
      ledg_q     <= '0;
      lcd_q      <= '0;
      hex_q      <= '0;
      sw_sync1_q <= '0;
      sw_sync2_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      ledr_q     <= ledr_d;
      ledg_q     <= ledg_d;
      lcd_q      <= lcd_d;
      hex_q      <= hex_d;
      sw_sync1_q <= io_sw_i;
      sw_sync2_q <= sw_sync1_q;
      rdata_q    <= rden_i ? rdata_d : '0;
      rvalid_q   <= rden_i;
    end
  end

`ifdef IO_DEBOUNCE_EN
  for (genvar g = 0; g < SW_W; g++) begin : g_db
    sw_debounce #(.CYC(DEBOUNCE_CYC)) u_db (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .sync_i (sw_sync2_q[g]),
      .filt_o (sw_filt[g])
    );
  end
`else
  assign sw_filt = sw_sync2_q;
`endif

  assign io_ledr_o = ledr_q;
  assign io_ledg_o = ledg_q;
  assign io_lcd_o  = lcd_q;
  assign io_hex_o  = hex_q;
  assign rdata_o   = rdata_q;
  assign rvalid_o  = rvalid_q;

endmodule

// File: tb/tb_io_periph_bank.sv
// Directed bench for io_periph_bank (NUM_HEX=4, DEBOUNCE_CYC=4).
module tb_io_periph_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  bmask;
  logic        wren, rden, rvalid;
  logic [16:0] sw, ledr;
  logic [7:0]  ledg;
  logic [31:0] lcd;
  logic [27:0] hex;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  io_periph_bank #(
    .NUM_HEX(4), .LEDR_W(17), .LEDG_W(8), .SW_W(17), .DEBOUNCE_CYC(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .wdata_i(wdata), .bmask_i(bmask),
    .wren_i(wren), .rden_i(rden), .rdata_o(rdata), .rvalid_o(rvalid),
    .io_sw_i(sw), .io_ledr_o(ledr), .io_ledg_o(ledg), .io_lcd_o(lcd), .io_hex_o(hex)
  );

  // All drive tasks start and end at a falling edge.
  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    addr = a; wdata = d; bmask = m; wren = 1'b1;
    @(negedge clk);
    wren = 1'b0; bmask = 4'h0;
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] d, output logic v);
    addr = a; rden = 1'b1;
    @(negedge clk);
    d = rdata; v = rvalid;
    rden = 1'b0;
  endtask

  task automatic test_reset;
    if ({ledr, ledg, lcd, hex} !== '0) begin
      bad++; $display("FAIL reset_outputs got ledr=%h ledg=%h lcd=%h hex=%h want 0", ledr, ledg, lcd, hex);
    end
    total++;
    if ({rvalid, rdata} !== '0) begin
      bad++; $display("FAIL reset_rd got rvalid=%b rdata=%h want 0/0", rvalid, rdata);
    end
    total++;
  endtask

  task automatic test_ledr;
    logic [31:0] d; logic v;
    do_store(32'h7000, 32'hFFFF_FFFF, 4'hF);
    if (ledr !== 17'h1FFFF) begin bad++; $display("FAIL ledr_full got %h want 1ffff", ledr); end
    total++;
    do_load(32'h7000, d, v);
    if (v !== 1'b1 || d !== 32'h0001_FFFF) begin
      bad++; $display("FAIL ledr_read got v=%b d=%h want 1/0001ffff", v, d);
    end
    total++;
    @(negedge clk);
    if (rvalid !== 1'b0 || rdata !== 32'h0) begin
      bad++; $display("FAIL rvalid_one_cycle got v=%b d=%h want 0/0", rvalid, rdata);
    end
    total++;
    do_store(32'h7000, 32'h0, 4'h4);
    if (ledr !== 17'h0FFFF) begin bad++; $display("FAIL ledr_byte2 got %h want 0ffff", ledr); end
    total++;
  endtask

  task automatic test_ledg;
    logic [31:0] d; logic v;
    do_store(32'h7010, 32'h1234_5678, 4'h2);
    if (ledg !== 8'h00) begin bad++; $display("FAIL ledg_wide_byte got %h want 00", ledg); end
    total++;
    do_store(32'hABCD_7010, 32'h0000_00A5, 4'h1);
    if (ledg !== 8'hA5) begin bad++; $display("FAIL ledg_hi_addr got %h want a5", ledg); end
    total++;
    do_store(32'h7010, 32'hFFFF_FF00, 4'hE);
    if (ledg !== 8'hA5) begin bad++; $display("FAIL ledg_masked got %h want a5", ledg); end
    total++;
    do_load(32'h7010, d, v);
    if (d !== 32'h0000_00A5) begin bad++; $display("FAIL ledg_read got %h want 000000a5", d); end
    total++;
  endtask

  task automatic test_hex;
    logic [31:0] d; logic v;
    do_store(32'h7020, 32'h4079_2440, 4'h5);
    if (hex !== {7'h00, 7'h79, 7'h00, 7'h40}) begin
      bad++; $display("FAIL hex_mask5 got %h want %h", hex, {7'h00, 7'h79, 7'h00, 7'h40});
    end
    total++;
    do_store(32'h7020, 32'h0000_FF00, 4'h2);
    if (hex !== {7'h00, 7'h79, 7'h7F, 7'h40}) begin
      bad++; $display("FAIL hex_bit7 got %h want %h", hex, {7'h00, 7'h79, 7'h7F, 7'h40});
    end
    total++;
    do_load(32'h7020, d, v);
    if (d !== 32'h0079_7F40) begin bad++; $display("FAIL hex_read got %h want 00797f40", d); end
    total++;
  endtask

  task automatic test_lcd_raw;
    logic [31:0] d; logic v;
    do_store(32'h7030, 32'h0000_AAAA, 4'hF);
    addr = 32'h7030; wdata = 32'h0000_1234; bmask = 4'hF; wren = 1'b1; rden = 1'b1;
    @(negedge clk);
    wren = 1'b0; rden = 1'b0; bmask = 4'h0;
    if (rdata !== 32'h0000_AAAA) begin bad++; $display("FAIL raw_old got %h want 0000aaaa", rdata); end
    total++;
    if (lcd !== 32'h0000_1234) begin bad++; $display("FAIL raw_lcd got %h want 00001234", lcd); end
    total++;
    do_load(32'h7030, d, v);
    if (d !== 32'h0000_1234) begin bad++; $display("FAIL raw_new got %h want 00001234", d); end
    total++;
    do_store(32'h7030, 32'h5A00_0000, 4'h8);
    if (lcd !== 32'h5A00_1234) begin bad++; $display("FAIL lcd_byte3 got %h want 5a001234", lcd); end
    total++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp_d [3];
    logic [31:0] a [3];
    a[0] = 32'h7000; a[1] = 32'h7010; a[2] = 32'h7030;
    exp_d[0] = 32'h0000_FFFF; exp_d[1] = 32'h0000_00A5; exp_d[2] = 32'h5A00_1234;
    rden = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr = a[i];
      @(negedge clk);
      if (rvalid !== 1'b1 || rdata !== exp_d[i]) begin
        bad++; $display("FAIL b2b_%0d got v=%b d=%h want 1/%h", i, rvalid, rdata, exp_d[i]);
      end
      total++;
    end
    rden = 1'b0;
  endtask

  task automatic test_unmapped;
    logic [31:0] d; logic v;
    do_store(32'h7027, 32'hFFFF_FFFF, 4'hF);
    do_store(32'h7800, 32'hFFFF_FFFF, 4'hF);
    do_store(32'h7004, 32'hFFFF_FFFF, 4'hF);
    if (hex !== {7'h00, 7'h79, 7'h7F, 7'h40} || ledr !== 17'h0FFFF || ledg !== 8'hA5 || lcd !== 32'h5A00_1234) begin
      bad++; $display("FAIL unmapped_store got hex=%h ledr=%h ledg=%h lcd=%h", hex, ledr, ledg, lcd);
    end
    total++;
    do_load(32'h1234, d, v);
    if (v !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL unmapped_read got v=%b d=%h want 1/0", v, d); end
    total++;
    do_load(32'h7024, d, v);
    if (d !== 32'h0) begin bad++; $display("FAIL absent_digit got %h want 0", d); end
    total++;
  endtask

`ifdef IO_DEBOUNCE_EN
  task automatic test_debounce;
    logic [31:0] d; logic v;
    sw = 17'h1;
    repeat (3) @(negedge clk);
    sw = 17'h0;
    repeat (10) @(negedge clk);
    do_load(32'h7800, d, v);
    if (d !== 32'h0) begin bad++; $display("FAIL db_glitch got %h want 0", d); end
    total++;
    sw = 17'h1;
    repeat (8) @(negedge clk);
    do_load(32'h7800, d, v);
    if (d !== 32'h1) begin bad++; $display("FAIL db_stable got %h want 1", d); end
    total++;
  endtask
`endif

  task automatic test_sw;
    logic [31:0] d; logic v;
`ifdef IO_DEBOUNCE_EN
    sw = 17'h15A5A;
    repeat (12) @(negedge clk);
    do_load(32'h7800, d, v);
    if (d !== 32'h0001_5A5A) begin bad++; $display("FAIL sw_read got %h want 00015a5a", d); end
    total++;
`else
    sw = 17'h15A5A; addr = 32'h7800; rden = 1'b1;
    repeat (2) @(negedge clk);
    if (rdata !== 32'h0) begin bad++; $display("FAIL sw_sync_early got %h want 0", rdata); end
    total++;
    @(negedge clk);
    rden = 1'b0;
    if (rdata !== 32'h0001_5A5A) begin bad++; $display("FAIL sw_sync_late got %h want 00015a5a", rdata); end
    total++;
    do_load(32'h0000_7802, d, v);
    if (d !== 32'h0001_5A5A) begin bad++; $display("FAIL sw_read got %h want 00015a5a", d); end
    total++;
`endif
  endtask

  task automatic test_reset_midstream;
    logic [31:0] d; logic v;
    addr = 32'h7030; rden = 1'b1;
    @(posedge clk); #1;
    rden = 1'b0;
    rst = 1'b1; #1;
    if (rvalid !== 1'b0 || rdata !== 32'h0) begin
      bad++; $display("FAIL rst_kills_rvalid got v=%b d=%h want 0/0", rvalid, rdata);
    end
    total++;
    @(negedge clk);
    rst = 1'b0;
    do_store(32'h7010, 32'h0000_00A5, 4'h1);
    if (ledg !== 8'hA5) begin bad++; $display("FAIL post_rst_store got %h want a5", ledg); end
    total++;
    addr = 32'h7010; rden = 1'b1;
    #2 rst = 1'b1; #1;
    if (ledg !== 8'h00 || ledr !== 17'h0 || lcd !== 32'h0 || hex !== 28'h0) begin
      bad++; $display("FAIL rst_async got ledg=%h ledr=%h lcd=%h hex=%h want 0", ledg, ledr, lcd, hex);
    end
    total++;
    @(negedge clk);
    rden = 1'b0; rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (rvalid !== 1'b0 || rdata !== 32'h0) begin
        bad++; $display("FAIL rst_no_rvalid_%0d got v=%b d=%h want 0/0", i, rvalid, rdata);
      end
      total++;
    end
    do_load(32'h7010, d, v);
    if (v !== 1'b1 || d !== 32'h0) begin bad++; $display("FAIL post_rst_read got v=%b d=%h want 1/0", v, d); end
    total++;
  endtask

  initial begin
    rst = 1'b1; addr = '0; wdata = '0; bmask = '0; wren = 1'b0; rden = 1'b0; sw = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_ledr;
    test_ledg;
    test_hex;
    test_lcd_raw;
    test_back_to_back;
    test_unmapped;
`ifdef IO_DEBOUNCE_EN
    test_debounce;
`endif
    test_sw;
    test_reset_midstream;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/io_periph_bank.md
IO_PERIPH_BANK -- requirements
Module: io_periph_bank

Interface
REQ-001 SHALL have parameter NUM_HEX, default 8, number of 7-segment digits (1..16).
REQ-002 SHALL have parameter LEDR_W, default 17, red LED width (1..32).
REQ-003 SHALL have parameter LEDG_W, default 8, green LED width (1..32).
REQ-004 SHALL have parameter SW_W, default 17, switch width (1..32).
REQ-005 SHALL have parameter DEBOUNCE_CYC, default 16, switch stable-cycle count (2..65535).
REQ-006 SHALL have port clk_i  in  1  sole clock, rising edge.
REQ-007 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-008 SHALL have port addr_i  in  32  byte address of LSU access.
REQ-009 SHALL have port wdata_i  in  32  store data.
REQ-010 SHALL have port bmask_i  in  4  byte enables, bit n = wdata_i[8n+7:8n].
REQ-011 SHALL have port wren_i  in  1  store strobe, one access per cycle.
REQ-012 SHALL have port rden_i  in  1  load strobe.
REQ-013 SHALL have port rdata_o  out  32  load data.
REQ-014 SHALL have port rvalid_o  out  1  rdata_o valid.
REQ-015 SHALL have port io_sw_i  in  SW_W  raw asynchronous switches.
REQ-016 SHALL have ports io_ledr_o (LEDR_W), io_ledg_o (LEDG_W), io_lcd_o (32), io_hex_o (7*NUM_HEX, digit i at [7i+6:7i]), all out.

Function
REQ-017 SHALL decode address map: LEDR 0x7000, LEDG 0x7010, HEX digit i byte 0x7020+i, LCD 0x7030, SW 0x7800; decode on addr_i[15:2] word, higher bits ignored.
REQ-018 SHALL update output registers on the clock edge where wren_i=1, per enabled byte only; bits beyond LEDR_W/LEDG_W discarded.
REQ-019 SHALL store HEX bytes as 7 bits, bit 7 ignored; digit bytes with i>=NUM_HEX ignored.
REQ-020 SHALL ignore writes to SW region and to unmapped addresses, with no side effects.
REQ-021 SHALL register loads: rden_i at edge N gives rvalid_o=1 and rdata_o for exactly cycle N+1; back-to-back loads sustain one per cycle.
REQ-022 SHALL return zero-extended register contents on reads, HEX bytes as {0,7 bits}, unmapped or absent digits as 0.
REQ-023 SHALL return pre-write contents when wren_i and rden_i target the same word in the same cycle.
REQ-024 SHALL treat rden_i and wren_i to different words in one cycle as independent.
REQ-025 SHALL synchronise io_sw_i through a two-flop synchroniser before any use; SW read reflects the filtered value.
REQ-026 SHALL hold rdata_o at 0 when rvalid_o=0.

Reset
REQ-027 SHALL on rst_i=1 immediately clear all output registers, rdata_o, rvalid_o, synchroniser flops, filtered switch value and debounce counters to 0.
REQ-028 SHALL discard any load issued in the cycle reset asserts; no rvalid_o after deassertion without a new rden_i.
REQ-029 SHALL accept accesses from the first rising edge after rst_i deasserts.

Configuration
REQ-030 SHALL, with IO_DEBOUNCE_EN defined, update each filtered switch bit only after its synchronised value differs from the filtered value for DEBOUNCE_CYC consecutive cycles; counter restarts on any return to filtered value.
REQ-031 SHALL, without IO_DEBOUNCE_EN, use the synchronised value directly (SW read latency 2 cycles from input change), no counters instantiated.

Structure
REQ-032 SHALL place address constants (LEDR/LEDG/HEX/LCD/SW bases) and the region-select enum in a shared package io_periph_pkg.
REQ-033 SHALL implement per-bit filtering in one sub-module sw_debounce, instantiated SW_W times under IO_DEBOUNCE_EN.

Verification
REQ-034 SHALL cover: store 0xFFFF_FFFF bmask 0xF to 0x7000, LEDR_W=17 -> io_ledr_o=0x1FFFF, load 0x7000 next cycle -> rdata_o=0x0001_FFFF with rvalid_o one cycle later.
REQ-035 SHALL cover: store 0x4079_2440 bmask 0x5 to 0x7020 -> hex0=0x40, hex2=0x79, hex1/hex3 unchanged at 0.
REQ-036 SHALL cover: same-cycle store 0x1234 and load to 0x7030 with prior value 0xAAAA -> rdata_o=0xAAAA, following load 0x1234.
REQ-037 SHALL cover (IO_DEBOUNCE_EN, DEBOUNCE_CYC=4): sw[0] toggled 1 for 3 cycles then 0 -> SW read 0; held 1 for 8 cycles -> SW read 0x1.
REQ-038 SHALL cover: rst_i asserted mid-stream after LEDG=0xA5 and pending load -> io_ledg_o=0 same cycle, rvalid_o=0 after release.
REQ-039 SHALL cover: store to 0x7027 with NUM_HEX=4 and load 0x1234 (unmapped) -> no output change, rdata_o=0.
